// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the memory bank controller and its storage array:
//   - state_t            : controller FSM encoding (ST_INIT, ST_READY)
//   - DEFAULT_DATA_WIDTH : default word width in bits
//   - DEFAULT_ADDR_WIDTH : default address width in bits
//   - PARITY_MAX_WIDTH   : widest word even_parity() accepts
//   - even_parity()      : XOR-reduction of a zero-extended data word
// -----------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    // Callers zero-extend narrower words; the extra zeros do not change parity.
    localparam int PARITY_MAX_WIDTH = 64;

    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage : memory_pkg

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// Single-port word storage, written on the rising clock edge, read
// combinationally at the same address.
// Ports:
//   clk    in   1           write clock
//   we     in   1           write enable
//   addr   in   ADDR_WIDTH  word address (shared by read and write)
//   wdata  in   WIDTH       write data
//   rdata  out  WIDTH       combinational read data of mem[addr]
// -----------------------------------------------------------------------------
module memory_array #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage has no reset branch; a reset would turn it into
    // thousands of flops. The controller's INIT fill clears it instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule : memory_array

// File: rtl/memory_bank_ctrl.sv
// -----------------------------------------------------------------------------
// memory_bank_ctrl
// DEPTH x DATA_WIDTH single-port memory with a valid/ready request port and a
// registered, one-cycle-latency read-response port. After every reset an init
// FSM zero-fills the array (DEPTH cycles); no request is accepted until then.
//
// Build option: define MEM_PARITY_EN to store an even-parity bit per word and
// add the inj_perr / rsp_perr ports.
//
// Ports:
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   1           request present
//   req_ready  out  1           high in READY; accept = req_valid && req_ready
//   req_write  in   1           1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH  word address
//   req_wdata  in   DATA_WIDTH  write data
//   rsp_valid  out  1           one-cycle pulse per accepted read
//   rsp_rdata  out  DATA_WIDTH  read data, held while rsp_valid = 0
//   init_done  out  1           high once the zero-fill has completed
//   inj_perr   in   1           (MEM_PARITY_EN) invert stored parity on a write
//   rsp_perr   out  1           (MEM_PARITY_EN) parity error, valid with rsp_valid
// -----------------------------------------------------------------------------
module memory_bank_ctrl
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
`ifdef MEM_PARITY_EN
    ,
    input  logic                  inj_perr,
    output logic                  rsp_perr
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    // init_ptr carries one extra bit so stepping past DEPTH-1 never wraps to 0.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   init_ptr;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_wdata;
    logic [MEM_WIDTH-1:0]  mem_rdata;
    logic [MEM_WIDTH-1:0]  wr_word;
    logic                  rd_accept;

    // ------------------------------------------------------------------
    // Word to store on a request write (data plus optional parity bit)
    // ------------------------------------------------------------------
`ifdef MEM_PARITY_EN
    logic [PARITY_MAX_WIDTH-1:0] wr_par_in;
    logic [PARITY_MAX_WIDTH-1:0] rd_par_in;

    always_comb begin
        wr_par_in                 = '0;
        wr_par_in[DATA_WIDTH-1:0] = req_wdata;
        rd_par_in                 = '0;
        rd_par_in[DATA_WIDTH-1:0] = mem_rdata[DATA_WIDTH-1:0];
    end

    assign wr_word = {even_parity(wr_par_in) ^ inj_perr, req_wdata};
`else
    assign wr_word = req_wdata;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            init_done <= (state_next == ST_READY);
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, handshake and array port steering
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = req_addr;
        mem_wdata  = wr_word;
        rd_accept  = 1'b0;

        case (state)
            ST_INIT: begin
                // Zero data has zero parity, so all-zero is a valid word.
                mem_we    = 1'b1;
                mem_addr  = init_ptr[ADDR_WIDTH-1:0];
                mem_wdata = '0;
                if (init_ptr == LAST_PTR) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                req_ready = 1'b1;
                mem_we    = req_valid && req_write;
                rd_accept = req_valid && !req_write;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    memory_array #(
        .WIDTH      (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memory_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Read response register: loaded only on an accepted read, so the data
    // holds between responses. A write and a following read see the new word
    // because the array read is combinational from the updated storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_accept;
            if (rd_accept) begin
                rsp_rdata <= mem_rdata[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_perr <= 1'b0;
        end else if (rd_accept) begin
            rsp_perr <= even_parity(rd_par_in) ^ mem_rdata[DATA_WIDTH];
        end
    end
`endif

endmodule : memory_bank_ctrl
